// File: rtl/pivot_pingpong_ram_pkg.sv
// Shared definitions for the pivot ping-pong RAM: default geometry and the
// per-bank fill state.
package pivot_pingpong_ram_pkg;

  localparam int unsigned PP_WIDTH  = 16;  // bits per lane element
  localparam int unsigned PP_L      = 4;   // lanes per word
  localparam int unsigned PP_DEPTH  = 16;  // words per bank
  localparam int unsigned PP_ADDR_W = 4;   // log2(PP_DEPTH)

  typedef enum logic [1:0] {
    PB_FREE    = 2'd0,
    PB_FILLING = 2'd1,
    PB_FULL    = 2'd2
  } bank_state_t;

  // State a bank moves to when it accepts a write; the last word fills it.
  function automatic bank_state_t state_after_write(input logic last_word);
    return last_word ? PB_FULL : PB_FILLING;
  endfunction

endpackage

// File: rtl/pivot_pingpong_ram_if.sv
// Loader/reader bus of the pivot ping-pong RAM.
//   master: the side driving writes, read requests, inhibit and release
//   slave : the RAM itself
// Signals: wr_en/wr_data/wr_ready/overflow (fill side),
//          rd_avail/rd_en/rd_addr/rd_inhibit/rd_release/rd_data/rd_valid/rel_err
//          (read side).
interface pivot_pingpong_ram_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned L      = 4,
  parameter int unsigned ADDR_W = 4
);

  logic                 wr_en;
  logic [L*WIDTH-1:0]   wr_data;
  logic                 wr_ready;
  logic                 overflow;
  logic                 rd_avail;
  logic                 rd_en;
  logic [ADDR_W-1:0]    rd_addr;
  logic                 rd_inhibit;
  logic                 rd_release;
  logic [L*WIDTH-1:0]   rd_data;
  logic                 rd_valid;
  logic                 rel_err;

  modport master (
    output wr_en, wr_data, rd_en, rd_addr, rd_inhibit, rd_release,
    input  wr_ready, overflow, rd_avail, rd_data, rd_valid, rel_err
  );

  modport slave (
    input  wr_en, wr_data, rd_en, rd_addr, rd_inhibit, rd_release,
    output wr_ready, overflow, rd_avail, rd_data, rd_valid, rel_err
  );

endinterface

// File: rtl/pivot_pingpong_ram_bank.sv
// pivot_bank: one bank of the ping-pong store. Simple dual-port RAM,
// DEPTH x (L*WIDTH), synchronous write, registered read address.
// Ports:
//   clk        clock
//   wr_en      write wr_data at wr_addr on this edge
//   wr_addr    write word address
//   wr_data    write word
//   rd_addr_en load rd_addr into the read-address register (low = hold)
//   rd_addr    read word address
//   rd_data    word at the registered read address
module pivot_bank #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned L      = 4,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [L*WIDTH-1:0]   wr_data,
  input  logic                 rd_addr_en,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [L*WIDTH-1:0]   rd_data
);

  logic [L*WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]  rd_addr_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_addr_en) rd_addr_q <= rd_addr;
  end

  assign rd_data = mem[rd_addr_q];

endmodule

// File: rtl/pivot_pingpong_ram.sv
// pivot_pingpong_ram: double-buffered pivot row/column store. The loader
// fills one bank while the PE array reads the other; banks swap roles as
// they fill and are released.
// Ports:
//   clk  clock (posedge)
//   rst  synchronous active-high reset
//   bus  slave side of pivot_pingpong_ram_if (write, read, inhibit, release,
//        status and sticky error flags)
// Parameter OUT_REG: 0 -> read latency 1, 1 -> extra output stage, latency 2.
module pivot_pingpong_ram
  import pivot_pingpong_ram_pkg::*;
#(
  parameter int unsigned WIDTH   = PP_WIDTH,
  parameter int unsigned L       = PP_L,
  parameter int unsigned DEPTH   = PP_DEPTH,
  parameter int unsigned ADDR_W  = PP_ADDR_W,
  parameter int unsigned OUT_REG = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  pivot_pingpong_ram_if.slave   bus
);

  localparam int unsigned DW = L * WIDTH;

  bank_state_t        state [2];
  logic               wr_bank;
  logic               rd_bank;
  logic [ADDR_W-1:0]  wr_ptr;
  logic               overflow_q;
  logic               rel_err_q;

  logic               wr_ready;
  logic               rd_avail;
  logic               wr_fire;
  logic               wr_last;
  logic               rd_issue;
  logic               rel_fire;

  always_comb begin
    wr_ready = (state[wr_bank] != PB_FULL);
    rd_avail = (state[rd_bank] == PB_FULL);
    wr_fire  = bus.wr_en & wr_ready;
    wr_last  = wr_fire && (wr_ptr == ADDR_W'(DEPTH - 1));
    rd_issue = bus.rd_en & ~bus.rd_inhibit & rd_avail;
    rel_fire = bus.rd_release & rd_avail;
  end

  // A released bank is FULL and the fill bank never is, so the release and
  // write updates below always target different banks.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned b = 0; b < 2; b++) state[b] <= PB_FREE;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_ptr     <= '0;
      overflow_q <= 1'b0;
      rel_err_q  <= 1'b0;
    end else begin
      for (int unsigned b = 0; b < 2; b++) begin
        if (rel_fire && (rd_bank == 1'(b)))
          state[b] <= PB_FREE;
        else if (wr_fire && (wr_bank == 1'(b)))
          state[b] <= state_after_write(wr_last);
      end
      if (wr_fire) begin
        wr_ptr <= wr_last ? '0 : wr_ptr + 1'b1;
        if (wr_last) wr_bank <= ~wr_bank;
      end
      if (rel_fire) rd_bank <= ~rd_bank;
      if (bus.wr_en && !wr_ready) overflow_q <= 1'b1;
      if (bus.rd_release && !rd_avail) rel_err_q <= 1'b1;
    end
  end

  // ---------------- banks ----------------
  logic [DW-1:0] bank_data [2];

  for (genvar g = 0; g < 2; g++) begin : g_bank
    pivot_bank #(
      .WIDTH  (WIDTH),
      .L      (L),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk        (clk),
      .wr_en      (wr_fire && (wr_bank == 1'(g))),
      .wr_addr    (wr_ptr),
      .wr_data    (bus.wr_data),
      .rd_addr_en (~bus.rd_inhibit),
      .rd_addr    (bus.rd_addr),
      .rd_data    (bank_data[g])
    );
  end

  // ---------------- read pipeline ----------------
  // The bank select is captured together with the address so a read issued
  // just before a release still returns the old bank's word.
  logic          rd_sel_q;
  logic          valid1_q;
  logic [DW-1:0] data1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_sel_q <= 1'b0;
      valid1_q <= 1'b0;
    end else if (!bus.rd_inhibit) begin
      rd_sel_q <= rd_bank;
      valid1_q <= rd_issue;
    end
  end

  assign data1 = rd_sel_q ? bank_data[1] : bank_data[0];

  if (OUT_REG != 0) begin : g_out_reg
    logic          valid2_q;
    logic [DW-1:0] data2_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        valid2_q <= 1'b0;
        data2_q  <= '0;
      end else if (!bus.rd_inhibit) begin
        valid2_q <= valid1_q;
        data2_q  <= data1;
      end
    end

    assign bus.rd_valid = valid2_q;
    assign bus.rd_data  = data2_q;
  end else begin : g_no_out_reg
    assign bus.rd_valid = valid1_q;
    assign bus.rd_data  = data1;
  end

  assign bus.wr_ready = wr_ready;
  assign bus.rd_avail = rd_avail;
  assign bus.overflow = overflow_q;
  assign bus.rel_err  = rel_err_q;

endmodule

// File: tb/tb_pivot_pingpong_ram.sv
// Bench for pivot_pingpong_ram: two instances (OUT_REG=0 and OUT_REG=1)
// driven by identical stimulus and checked each cycle against a
// transaction-level model, plus directed vectors and corner sequences.
module tb_pivot_pingpong_ram;
  import pivot_pingpong_ram_pkg::*;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned L      = 4;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DW     = L * WIDTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            d_wr_en;
  logic [DW-1:0]   d_wr_data;
  logic            d_rd_en;
  logic [ADDR_W-1:0] d_rd_addr;
  logic            d_inh;
  logic            d_rel;

  pivot_pingpong_ram_if #(.WIDTH(WIDTH), .L(L), .ADDR_W(ADDR_W)) bus0 ();
  pivot_pingpong_ram_if #(.WIDTH(WIDTH), .L(L), .ADDR_W(ADDR_W)) bus1 ();

  assign bus0.wr_en      = d_wr_en;
  assign bus0.wr_data    = d_wr_data;
  assign bus0.rd_en      = d_rd_en;
  assign bus0.rd_addr    = d_rd_addr;
  assign bus0.rd_inhibit = d_inh;
  assign bus0.rd_release = d_rel;
  assign bus1.wr_en      = d_wr_en;
  assign bus1.wr_data    = d_wr_data;
  assign bus1.rd_en      = d_rd_en;
  assign bus1.rd_addr    = d_rd_addr;
  assign bus1.rd_inhibit = d_inh;
  assign bus1.rd_release = d_rel;

  pivot_pingpong_ram #(.WIDTH(WIDTH), .L(L), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OUT_REG(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  pivot_pingpong_ram #(.WIDTH(WIDTH), .L(L), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OUT_REG(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each bank is a word count plus a full flag; the fill position is simply
  // the count of the fill bank. Reads are a history of non-stalled cycles:
  // output at latency n is the entry n stalls-free cycles back.
  logic [DW-1:0] m_mem [2][DEPTH];
  int            m_count [2];
  bit            m_full [2];
  int            m_wb, m_rb;
  bit            m_ovf, m_rel;
  bit            hv [$];
  logic [DW-1:0] hd [$];

  task automatic model_step();
    bit ready, avail, issue;
    if (rst) begin
      for (int b = 0; b < 2; b++) begin m_count[b] = 0; m_full[b] = 0; end
      m_wb = 0; m_rb = 0; m_ovf = 0; m_rel = 0;
      hv.delete(); hd.delete();
      return;
    end
    ready = !m_full[m_wb];
    avail = m_full[m_rb];
    issue = d_rd_en && !d_inh && avail;
    if (!d_inh) begin
      hv.push_front(issue);
      hd.push_front(m_mem[m_rb][d_rd_addr]);
      while (hv.size() > 2) begin void'(hv.pop_back()); void'(hd.pop_back()); end
    end
    if (d_rel) begin
      if (avail) begin
        m_full[m_rb] = 0; m_count[m_rb] = 0; m_rb ^= 1;
      end else m_rel = 1;
    end
    if (d_wr_en) begin
      if (ready) begin
        m_mem[m_wb][m_count[m_wb]] = d_wr_data;
        m_count[m_wb]++;
        if (m_count[m_wb] == DEPTH) begin m_full[m_wb] = 1; m_wb ^= 1; end
      end else m_ovf = 1;
    end
  endtask

  task automatic check_model();
    bit ev0, ev1;
    ev0 = (hv.size() > 0) ? hv[0] : 1'b0;
    ev1 = (hv.size() > 1) ? hv[1] : 1'b0;
    chk("m_wr_ready0", DW'(bus0.wr_ready), DW'(!m_full[m_wb]));
    chk("m_wr_ready1", DW'(bus1.wr_ready), DW'(!m_full[m_wb]));
    chk("m_rd_avail0", DW'(bus0.rd_avail), DW'(m_full[m_rb]));
    chk("m_rd_avail1", DW'(bus1.rd_avail), DW'(m_full[m_rb]));
    chk("m_overflow0", DW'(bus0.overflow), DW'(m_ovf));
    chk("m_overflow1", DW'(bus1.overflow), DW'(m_ovf));
    chk("m_rel_err0",  DW'(bus0.rel_err),  DW'(m_rel));
    chk("m_rel_err1",  DW'(bus1.rel_err),  DW'(m_rel));
    chk("m_rd_valid0", DW'(bus0.rd_valid), DW'(ev0));
    chk("m_rd_valid1", DW'(bus1.rd_valid), DW'(ev1));
    if (ev0) chk("m_rd_data0", bus0.rd_data, hd[0]);
    if (ev1) chk("m_rd_data1", bus1.rd_data, hd[1]);
  endtask

  // Apply current inputs across one rising edge, then check after it.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle();
    d_wr_en = 0; d_wr_data = '0; d_rd_en = 0; d_rd_addr = '0; d_inh = 0; d_rel = 0;
  endtask

  typedef struct {
    bit              rd_en;
    logic [ADDR_W-1:0] addr;
    bit              ev0;
    logic [DW-1:0]   ed0;
    bit              ev1;
    logic [DW-1:0]   ed1;
  } vec_t;

  vec_t vt [DEPTH+1];
  int   hold;

  initial begin
    // read-back vectors for bank0 holding words 1..16
    for (int i = 0; i <= int'(DEPTH); i++) begin
      vt[i].rd_en = (i < int'(DEPTH));
      vt[i].addr  = ADDR_W'(i);
      vt[i].ev0   = (i < int'(DEPTH));
      vt[i].ed0   = DW'(i + 1);
      vt[i].ev1   = (i >= 1);
      vt[i].ed1   = DW'(i);
    end

    // 1. reset, fill bank0 with 1..16
    idle();
    rst = 1;
    cycle(); cycle();
    chk("rst_wr_ready", DW'(bus0.wr_ready), DW'(1));
    chk("rst_rd_avail", DW'(bus0.rd_avail), DW'(0));
    chk("rst_rd_valid", DW'(bus1.rd_valid), DW'(0));
    rst = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      d_wr_en = 1; d_wr_data = DW'(i + 1);
      if (i == int'(DEPTH) - 1) chk("pre_full_avail", DW'(bus0.rd_avail), DW'(0));
      cycle();
    end
    idle();
    chk("fill0_rd_avail", DW'(bus0.rd_avail), DW'(1));
    chk("fill0_wr_ready", DW'(bus0.wr_ready), DW'(1));

    // 2. back-to-back reads, latency 1 and 2
    for (int i = 0; i <= int'(DEPTH); i++) begin
      d_rd_en = vt[i].rd_en; d_rd_addr = vt[i].addr;
      cycle();
      chk("vec_valid0", DW'(bus0.rd_valid), DW'(vt[i].ev0));
      chk("vec_valid1", DW'(bus1.rd_valid), DW'(vt[i].ev1));
      if (vt[i].ev0) chk("vec_data0", bus0.rd_data, vt[i].ed0);
      if (vt[i].ev1) chk("vec_data1", bus1.rd_data, vt[i].ed1);
    end
    idle();

    // 3. fill bank1, overflow, release
    for (int i = 0; i < int'(DEPTH); i++) begin
      d_wr_en = 1; d_wr_data = DW'(32'h100 + i);
      cycle();
    end
    chk("both_full_wr_ready", DW'(bus0.wr_ready), DW'(0));
    d_wr_data = DW'(64'hdead);
    cycle();
    chk("overflow0", DW'(bus0.overflow), DW'(1));
    chk("overflow1", DW'(bus1.overflow), DW'(1));
    idle();
    d_rel = 1;
    cycle();
    d_rel = 0;
    chk("rel_wr_ready", DW'(bus0.wr_ready), DW'(1));
    chk("rel_rd_avail", DW'(bus0.rd_avail), DW'(1));

    // 4. read word5 of bank1 then stall three cycles
    d_rd_en = 1; d_rd_addr = 5;
    cycle();
    chk("inh_first0", bus0.rd_data, DW'(32'h105));
    d_rd_addr = 9; d_inh = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("inh_hold_valid0", DW'(bus0.rd_valid), DW'(1));
      chk("inh_hold_data0", bus0.rd_data, DW'(32'h105));
      chk("inh_hold_valid1", DW'(bus1.rd_valid), DW'(0));
    end
    idle();
    cycle();
    chk("inh_after_valid0", DW'(bus0.rd_valid), DW'(0));
    chk("inh_after_valid1", DW'(bus1.rd_valid), DW'(1));
    chk("inh_after_data1", bus1.rd_data, DW'(32'h105));

    // 5. final write of one bank together with release of the other (twice)
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        d_wr_en = 1; d_wr_data = DW'(32'h200 + 32'h100 * r + i);
        d_rel = (i == int'(DEPTH) - 1);
        cycle();
      end
      idle();
      chk("swap_rd_avail", DW'(bus0.rd_avail), DW'(1));
      chk("swap_wr_ready", DW'(bus0.wr_ready), DW'(1));
      d_rd_en = 1; d_rd_addr = 3;
      cycle();
      idle();
      chk("swap_rd_data0", bus0.rd_data, DW'(32'h203 + 32'h100 * r));
      cycle();
      chk("swap_rd_data1", bus1.rd_data, DW'(32'h203 + 32'h100 * r));
    end

    // 6. release with nothing full, then reset mid-fill
    d_rel = 1;
    cycle();              // releases the full bank1
    cycle();              // nothing full any more
    d_rel = 0;
    chk("rel_err0", DW'(bus0.rel_err), DW'(1));
    chk("rel_err_avail", DW'(bus0.rd_avail), DW'(0));
    chk("rel_err_ready", DW'(bus0.wr_ready), DW'(1));
    for (int i = 0; i < 7; i++) begin
      d_wr_en = 1; d_wr_data = DW'(32'h300 + i);
      cycle();
    end
    rst = 1;
    cycle();
    rst = 0;
    idle();
    chk("mid_rst_wr_ready", DW'(bus0.wr_ready), DW'(1));
    chk("mid_rst_rd_avail", DW'(bus0.rd_avail), DW'(0));
    chk("mid_rst_rd_valid", DW'(bus1.rd_valid), DW'(0));
    chk("mid_rst_overflow", DW'(bus0.overflow), DW'(0));
    chk("mid_rst_rel_err",  DW'(bus0.rel_err),  DW'(0));

    // 7. random traffic against the model
    hold = 0;
    for (int n = 0; n < 3000; n++) begin
      d_wr_en   = ($urandom_range(0, 2) != 0);
      d_wr_data = {$urandom, $urandom};
      d_rd_en   = ($urandom_range(0, 3) != 0);
      d_rd_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      d_rel     = ($urandom_range(0, 11) == 0);
      // keep the stall off right after a release so a held word never comes
      // from a bank that the loader is already refilling
      d_inh     = (hold == 0) && ($urandom_range(0, 3) == 0);
      if (hold > 0) hold--;
      if (d_rel) hold = 2;
      rst       = ($urandom_range(0, 599) == 0);
      cycle();
    end
    rst = 0;
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
